// File: rtl/l2_pkg.sv
// l2_pkg: shared widths, FSM states and entry layout for the L2 victim buffer.
// Line width follows L2_OFFSET; beats per line follow L2_BEAT_W.
package l2_pkg;

    localparam int L2_BEAT_W  = 64;
    localparam int L2_OFFSET  = 5;
    localparam int L2_LINE_W  = 8 * (2 ** L2_OFFSET);
    localparam int L2_BEATS   = L2_LINE_W / L2_BEAT_W;
    localparam int L2_BEAT_IW = $clog2(L2_BEATS);

    typedef enum logic [1:0] {
        IDLE,
        BURST,
        GAP
    } vb_state_t;

    typedef struct packed {
        logic                 valid;
        logic [31:L2_OFFSET]  line_addr;
        logic [L2_LINE_W-1:0] data;
    } vb_entry_t;

endpackage

// File: rtl/l2_vb_fifo.sv
// l2_vb_fifo: victim entry storage, FIFO pointers and occupancy,
// plus the line-address match that selects the youngest matching entry.
module l2_vb_fifo
    import l2_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 push,
    input  logic [31:L2_OFFSET]  push_addr,
    input  logic [L2_LINE_W-1:0] push_data,
    input  logic                 pop,
    input  logic [31:L2_OFFSET]  lookup_line,
    output logic                 can_push,
    output logic                 not_empty,
    output logic [31:L2_OFFSET]  head_addr,
    output logic [L2_LINE_W-1:0] head_data,
    output logic                 match_any,
    output logic [L2_LINE_W-1:0] match_data
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    vb_entry_t      ent [DEPTH];
    logic [PW-1:0]  rd_ptr;
    logic [PW-1:0]  wr_ptr;
    logic [CW-1:0]  count;
    logic [PW-1:0]  idx;

    // Only valid bits are reset; line payloads keep their contents.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                ent[i].valid <= 1'b0;
            end
        end else begin
            if (push) begin
                ent[wr_ptr] <= '{valid: 1'b1, line_addr: push_addr, data: push_data};
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) begin
                ent[rd_ptr].valid <= 1'b0;
                rd_ptr            <= rd_ptr + 1'b1;
            end
            count <= count + CW'(push) - CW'(pop);
        end
    end

    assign can_push  = (count < CW'(DEPTH));
    assign not_empty = (count != '0);
    assign head_addr = ent[rd_ptr].line_addr;
    assign head_data = ent[rd_ptr].data;

    // Walk from oldest to youngest so the last hit is the newest copy.
    always_comb begin
        match_any  = 1'b0;
        match_data = '0;
        idx        = rd_ptr;
        for (int k = 0; k < DEPTH; k++) begin
            idx = rd_ptr + PW'(k);
            if (ent[idx].valid && (ent[idx].line_addr == lookup_line)) begin
                match_any  = 1'b1;
                match_data = ent[idx].data;
            end
        end
    end

endmodule

// File: rtl/l2_victim_buffer.sv
// l2_victim_buffer: queues dirty L2 victims and drains each as a write burst.
// Optional L2_VICTIM_FORWARD_EN adds lookup_hit/lookup_data forwarding.
module l2_victim_buffer
    import l2_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 evict_valid,
    output logic                 evict_ready,
    input  logic [31:0]          evict_addr,
    input  logic [L2_LINE_W-1:0] evict_data,
    input  logic [31:0]          lookup_addr,
    output logic                 lookup_conflict,
    output logic                 buf_empty,
    output logic                 pmem_write,
    output logic [31:0]          pmem_address,
    output logic [L2_BEAT_W-1:0] pmem_wdata,
    input  logic                 pmem_resp
`ifdef L2_VICTIM_FORWARD_EN
    ,
    output logic                 lookup_hit,
    output logic [L2_LINE_W-1:0] lookup_data
`endif
);

    vb_state_t             state;
    vb_state_t             state_nx;
    logic [L2_BEAT_IW-1:0] beat;
    logic [L2_BEAT_IW-1:0] beat_nx;
    logic                  last_beat;
    logic                  push;
    logic                  pop;
    logic                  not_empty;
    logic [31:L2_OFFSET]   head_addr;
    logic [L2_LINE_W-1:0]  head_data;
    logic [L2_LINE_W-1:0]  fwd_data;
    logic                  unused_lo;

    assign unused_lo = ^{evict_addr[L2_OFFSET-1:0], lookup_addr[L2_OFFSET-1:0]};

    assign push      = evict_valid & evict_ready;
    assign last_beat = (beat == L2_BEAT_IW'(L2_BEATS - 1));
    assign pop       = (state == BURST) & pmem_resp & last_beat;

    l2_vb_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .push        (push),
        .push_addr   (evict_addr[31:L2_OFFSET]),
        .push_data   (evict_data),
        .pop         (pop),
        .lookup_line (lookup_addr[31:L2_OFFSET]),
        .can_push    (evict_ready),
        .not_empty   (not_empty),
        .head_addr   (head_addr),
        .head_data   (head_data),
        .match_any   (lookup_conflict),
        .match_data  (fwd_data)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            beat  <= '0;
        end else begin
            state <= state_nx;
            beat  <= beat_nx;
        end
    end

    always_comb begin
        state_nx = state;
        beat_nx  = beat;
        unique case (state)
            IDLE: begin
                beat_nx = '0;
                if (not_empty) state_nx = BURST;
            end
            BURST: begin
                if (pmem_resp) begin
                    beat_nx = beat + 1'b1;
                    if (last_beat) state_nx = GAP;
                end
            end
            GAP:     state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Outputs idle at zero so reset and GAP present a quiet bus.
    always_comb begin
        pmem_write   = 1'b0;
        pmem_address = '0;
        pmem_wdata   = '0;
        if (state == BURST) begin
            pmem_write   = 1'b1;
            pmem_address = {head_addr, {L2_OFFSET{1'b0}}};
            pmem_wdata   = head_data[beat * L2_BEAT_W +: L2_BEAT_W];
        end
    end

    assign buf_empty = !not_empty && (state != BURST);

`ifdef L2_VICTIM_FORWARD_EN
    assign lookup_hit  = lookup_conflict;
    assign lookup_data = fwd_data;
`else
    logic unused_fwd;
    assign unused_fwd = ^fwd_data;
`endif

endmodule

// File: tb/tb_l2_victim_buffer.sv
// tb_l2_victim_buffer: directed and randomized checks of l2_victim_buffer
// against a queue-of-accepted-lines reference model.
module tb_l2_victim_buffer;
    import l2_pkg::*;

    localparam int LW    = L2_LINE_W;
    localparam int BW    = L2_BEAT_W;
    localparam int NB    = LW / BW;
    localparam int OFF   = L2_OFFSET;
    localparam int DEPTH = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          evict_valid = 1'b0;
    logic          evict_ready;
    logic [31:0]   evict_addr = '0;
    logic [LW-1:0] evict_data = '0;
    logic [31:0]   lookup_addr = '0;
    logic          lookup_conflict;
    logic          buf_empty;
    logic          pmem_write;
    logic [31:0]   pmem_address;
    logic [BW-1:0] pmem_wdata;
    logic          pmem_resp = 1'b0;
`ifdef L2_VICTIM_FORWARD_EN
    logic          lookup_hit;
    logic [LW-1:0] lookup_data;
`endif

    always #5 clk = ~clk;

    l2_victim_buffer #(.DEPTH(DEPTH)) dut (
        .clk             (clk),
        .rst             (rst),
        .evict_valid     (evict_valid),
        .evict_ready     (evict_ready),
        .evict_addr      (evict_addr),
        .evict_data      (evict_data),
        .lookup_addr     (lookup_addr),
        .lookup_conflict (lookup_conflict),
        .buf_empty       (buf_empty),
        .pmem_write      (pmem_write),
        .pmem_address    (pmem_address),
        .pmem_wdata      (pmem_wdata),
        .pmem_resp       (pmem_resp)
`ifdef L2_VICTIM_FORWARD_EN
        ,
        .lookup_hit      (lookup_hit),
        .lookup_data     (lookup_data)
`endif
    );

    typedef struct {
        logic [31:0]   addr;
        logic [LW-1:0] data;
    } line_t;

    line_t         acc_q[$];
    logic [31:0]   obs_a[$];
    logic [BW-1:0] obs_d[$];
    int            nbeats = 0;
    int            n_cmp  = 0;
    int            n_bad  = 0;

    function automatic logic [LW-1:0] rand_line();
        logic [LW-1:0] d;
        for (int i = 0; i < LW / 32; i++) d[i*32 +: 32] = $urandom;
        return d;
    endfunction

    function automatic logic [31:0] align(input logic [31:0] a);
        return {a[31:OFF], {OFF{1'b0}}};
    endfunction

    function automatic int pend();
        return acc_q.size() - nbeats / NB;
    endfunction

    function automatic logic [BW-1:0] slice(input logic [LW-1:0] d, input int b);
        return d[b*BW +: BW];
    endfunction

    function automatic logic model_conflict(input logic [31:0] la);
        for (int i = nbeats / NB; i < acc_q.size(); i++)
            if (align(acc_q[i].addr) == align(la)) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [LW-1:0] model_fwd(input logic [31:0] la);
        logic [LW-1:0] d = '0;
        for (int i = nbeats / NB; i < acc_q.size(); i++)
            if (align(acc_q[i].addr) == align(la)) d = acc_q[i].data;
        return d;
    endfunction

    task automatic clear_model();
        acc_q.delete();
        obs_a.delete();
        obs_d.delete();
        nbeats = 0;
    endtask

    // One clock: log what the edge will transfer, then settle at negedge.
    task automatic cycle();
        if (evict_valid && pend() < DEPTH)
            acc_q.push_back('{addr: evict_addr, data: evict_data});
        if (pmem_write && pmem_resp) begin
            obs_a.push_back(pmem_address);
            obs_d.push_back(pmem_wdata);
            nbeats++;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drain(output bit timed_out);
        int n = 0;
        evict_valid = 1'b0;
        pmem_resp   = 1'b1;
        while (pend() > 0 && n < 200) begin
            cycle();
            n++;
        end
        timed_out = (pend() > 0);
        cycle();
        cycle();
    endtask

    task automatic test_reset();
        #1 rst = 1'b0;
        #1;
        n_cmp++;
        if (evict_ready !== 1'b1 || buf_empty !== 1'b1 || lookup_conflict !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_flags: ready=%b empty=%b conflict=%b want 1 1 0",
                     evict_ready, buf_empty, lookup_conflict);
        end
        n_cmp++;
        if (pmem_write !== 1'b0 || pmem_address !== 32'h0 || pmem_wdata !== '0) begin
            n_bad++;
            $display("FAIL reset_pmem: write=%b addr=%h wdata=%h want 0 0 0",
                     pmem_write, pmem_address, pmem_wdata);
        end
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_single();
        logic [BW-1:0] exp_d [NB];
        bit to;
        clear_model();
        exp_d[0] = 64'h1111_1111_1111_1111;
        exp_d[1] = 64'h2222_2222_2222_2222;
        exp_d[2] = 64'h3333_3333_3333_3333;
        exp_d[3] = 64'h4444_4444_4444_4444;
        pmem_resp   = 1'b1;
        evict_valid = 1'b1;
        evict_addr  = 32'h0000_1234;
        evict_data  = {exp_d[3], exp_d[2], exp_d[1], exp_d[0]};
        cycle();
        evict_valid = 1'b0;
        n_cmp++;
        if (pmem_write !== 1'b0 || buf_empty !== 1'b0) begin
            n_bad++;
            $display("FAIL single_idle: write=%b empty=%b want 0 0", pmem_write, buf_empty);
        end
        cycle();
        n_cmp++;
        if (pmem_write !== 1'b1 || pmem_address !== 32'h0000_1220) begin
            n_bad++;
            $display("FAIL single_start: write=%b addr=%h want 1 00001220",
                     pmem_write, pmem_address);
        end
        repeat (NB) cycle();
        n_cmp++;
        if (pmem_write !== 1'b0 || buf_empty !== 1'b1) begin
            n_bad++;
            $display("FAIL single_gap: write=%b empty=%b want 0 1", pmem_write, buf_empty);
        end
        cycle();
        n_cmp++;
        if (pmem_write !== 1'b0 || buf_empty !== 1'b1 || obs_a.size() != NB) begin
            n_bad++;
            $display("FAIL single_end: write=%b empty=%b beats=%0d want 0 1 %0d",
                     pmem_write, buf_empty, obs_a.size(), NB);
        end
        for (int b = 0; b < NB && b < obs_a.size(); b++) begin
            n_cmp++;
            if (obs_a[b] !== 32'h0000_1220 || obs_d[b] !== exp_d[b]) begin
                n_bad++;
                $display("FAIL single_beat%0d: addr=%h data=%h want 00001220 %h",
                         b, obs_a[b], obs_d[b], exp_d[b]);
            end
        end
        drain(to);
    endtask

    task automatic test_fill();
        line_t ln [3];
        bit    to;
        int    n;
        clear_model();
        pmem_resp = 1'b0;
        for (int i = 0; i < 3; i++) begin
            ln[i].addr = 32'h2000_0000 + 32'(i * 32) + 32'($urandom_range(0, 31));
            ln[i].data = rand_line();
        end
        for (int i = 0; i < 2; i++) begin
            evict_valid = 1'b1;
            evict_addr  = ln[i].addr;
            evict_data  = ln[i].data;
            cycle();
        end
        n_cmp++;
        if (evict_ready !== 1'b0) begin
            n_bad++;
            $display("FAIL fill_full: ready=%b want 0", evict_ready);
        end
        evict_addr = ln[2].addr;
        evict_data = ln[2].data;
        repeat (4) begin
            n_cmp++;
            if (evict_ready !== 1'b0) begin
                n_bad++;
                $display("FAIL fill_hold: ready=%b want 0", evict_ready);
            end
            cycle();
        end
        pmem_resp = 1'b1;
        n = 0;
        while (acc_q.size() < 3 && n < 40) begin
            n_cmp++;
            if (evict_ready !== (pend() < DEPTH)) begin
                n_bad++;
                $display("FAIL fill_ready: ready=%b want %b beats=%0d",
                         evict_ready, pend() < DEPTH, nbeats);
            end
            cycle();
            n++;
        end
        n_cmp++;
        if (acc_q.size() != 3 || nbeats != NB) begin
            n_bad++;
            $display("FAIL fill_third: accepted=%0d beats=%0d want 3 %0d",
                     acc_q.size(), nbeats, NB);
        end
        drain(to);
        n_cmp++;
        if (to || obs_a.size() != 3 * NB) begin
            n_bad++;
            $display("FAIL fill_drain: beats=%0d timeout=%b want %0d 0",
                     obs_a.size(), to, 3 * NB);
        end
        for (int j = 0; j < obs_a.size() && j < 3 * NB; j++) begin
            n_cmp++;
            if (obs_a[j] !== align(ln[j/NB].addr) ||
                obs_d[j] !== slice(ln[j/NB].data, j % NB)) begin
                n_bad++;
                $display("FAIL fill_order%0d: addr=%h data=%h want %h %h", j, obs_a[j],
                         obs_d[j], align(ln[j/NB].addr), slice(ln[j/NB].data, j % NB));
            end
        end
    endtask

    task automatic test_backpressure();
        line_t         l;
        logic [31:0]   sa;
        logic [BW-1:0] sd;
        bit            prev_low, to;
        int            n, k;
        clear_model();
        pmem_resp   = 1'b0;
        l.addr      = $urandom;
        l.data      = rand_line();
        evict_valid = 1'b1;
        evict_addr  = l.addr;
        evict_data  = l.data;
        cycle();
        evict_valid = 1'b0;
        n = 0;
        while (!pmem_write && n < 10) begin
            cycle();
            n++;
        end
        n_cmp++;
        if (pmem_write !== 1'b1) begin
            n_bad++;
            $display("FAIL bp_start: write=%b want 1", pmem_write);
        end
        k = 0;
        prev_low = 1'b0;
        sa = '0;
        sd = '0;
        while (pmem_write && k < 20) begin
            if (prev_low) begin
                n_cmp++;
                if (pmem_address !== sa || pmem_wdata !== sd) begin
                    n_bad++;
                    $display("FAIL bp_stable: addr=%h data=%h want %h %h",
                             pmem_address, pmem_wdata, sa, sd);
                end
            end
            pmem_resp = (k % 2 == 1);
            sa        = pmem_address;
            sd        = pmem_wdata;
            prev_low  = !pmem_resp;
            cycle();
            k++;
        end
        n_cmp++;
        if (k != 2 * NB || obs_a.size() != NB) begin
            n_bad++;
            $display("FAIL bp_len: cycles=%0d beats=%0d want %0d %0d",
                     k, obs_a.size(), 2 * NB, NB);
        end
        for (int b = 0; b < NB && b < obs_a.size(); b++) begin
            n_cmp++;
            if (obs_a[b] !== align(l.addr) || obs_d[b] !== slice(l.data, b)) begin
                n_bad++;
                $display("FAIL bp_beat%0d: addr=%h data=%h want %h %h", b, obs_a[b],
                         obs_d[b], align(l.addr), slice(l.data, b));
            end
        end
        drain(to);
    endtask

    task automatic test_conflict();
        bit to;
        int n;
        clear_model();
        pmem_resp   = 1'b0;
        lookup_addr = 32'h8000_005C;
        #1;
        n_cmp++;
        if (lookup_conflict !== 1'b0) begin
            n_bad++;
            $display("FAIL conf_empty: conflict=%b want 0", lookup_conflict);
        end
        evict_valid = 1'b1;
        evict_addr  = 32'h8000_0040;
        evict_data  = rand_line();
        cycle();
        evict_valid = 1'b0;
        n_cmp++;
        if (lookup_conflict !== 1'b1) begin
            n_bad++;
            $display("FAIL conf_hit: conflict=%b want 1", lookup_conflict);
        end
        lookup_addr = 32'h8000_0060;
        #1;
        n_cmp++;
        if (lookup_conflict !== 1'b0) begin
            n_bad++;
            $display("FAIL conf_other: conflict=%b want 0", lookup_conflict);
        end
        lookup_addr = 32'h8000_005C;
        pmem_resp   = 1'b1;
        #1;
        n = 0;
        while (nbeats < NB && n < 20) begin
            n_cmp++;
            if (lookup_conflict !== 1'b1) begin
                n_bad++;
                $display("FAIL conf_drain: conflict=%b want 1", lookup_conflict);
            end
            cycle();
            n++;
        end
        n_cmp++;
        if (lookup_conflict !== 1'b0 || nbeats != NB) begin
            n_bad++;
            $display("FAIL conf_clear: conflict=%b beats=%0d want 0 %0d",
                     lookup_conflict, nbeats, NB);
        end
        drain(to);
    endtask

`ifdef L2_VICTIM_FORWARD_EN
    task automatic test_forward();
        logic [LW-1:0] x, y;
        bit            to;
        int            n;
        clear_model();
        pmem_resp   = 1'b0;
        x           = rand_line();
        y           = rand_line();
        evict_valid = 1'b1;
        evict_addr  = 32'h3000_0100;
        evict_data  = x;
        cycle();
        evict_addr  = 32'h3000_0104;
        evict_data  = y;
        cycle();
        evict_valid = 1'b0;
        lookup_addr = 32'h3000_0108;
        #1;
        n_cmp++;
        if (lookup_hit !== 1'b1 || lookup_data !== y) begin
            n_bad++;
            $display("FAIL fwd_young: hit=%b data=%h want 1 %h", lookup_hit, lookup_data, y);
        end
        pmem_resp = 1'b1;
        n = 0;
        while (nbeats < NB && n < 20) begin
            cycle();
            n++;
        end
        #1;
        n_cmp++;
        if (lookup_hit !== 1'b1 || lookup_data !== y) begin
            n_bad++;
            $display("FAIL fwd_afterpop: hit=%b data=%h want 1 %h", lookup_hit, lookup_data, y);
        end
        drain(to);
    endtask
`endif

    task automatic test_reset_mid();
        int n;
        clear_model();
        pmem_resp   = 1'b1;
        evict_valid = 1'b1;
        evict_addr  = 32'h5000_0020;
        evict_data  = rand_line();
        cycle();
        evict_addr  = 32'h5000_0040;
        evict_data  = rand_line();
        cycle();
        evict_valid = 1'b0;
        lookup_addr = 32'h5000_0020;
        n = 0;
        while (nbeats < 2 && n < 20) begin
            cycle();
            n++;
        end
        n_cmp++;
        if (pmem_write !== 1'b1) begin
            n_bad++;
            $display("FAIL rmid_pre: write=%b want 1", pmem_write);
        end
        #2 rst = 1'b0;
        #1;
        n_cmp++;
        if (pmem_write !== 1'b0 || buf_empty !== 1'b1 ||
            evict_ready !== 1'b1 || lookup_conflict !== 1'b0) begin
            n_bad++;
            $display("FAIL rmid_async: write=%b empty=%b ready=%b conflict=%b want 0 1 1 0",
                     pmem_write, buf_empty, evict_ready, lookup_conflict);
        end
        @(negedge clk);
        rst = 1'b1;
        clear_model();
        repeat (10) cycle();
        n_cmp++;
        if (obs_a.size() != 0 || pmem_write !== 1'b0 || buf_empty !== 1'b1) begin
            n_bad++;
            $display("FAIL rmid_after: beats=%0d write=%b empty=%b want 0 0 1",
                     obs_a.size(), pmem_write, buf_empty);
        end
    endtask

    task automatic test_random();
        bit to;
        int h;
        clear_model();
        for (int c = 0; c < 400; c++) begin
            evict_valid = ($urandom_range(0, 2) != 0);
            evict_addr  = 32'h4000_0000 | ($urandom_range(0, 3) << 5) | $urandom_range(0, 31);
            evict_data  = rand_line();
            pmem_resp   = 1'($urandom_range(0, 1));
            lookup_addr = 32'h4000_0000 | ($urandom_range(0, 3) << 5) | $urandom_range(0, 31);
            #1;
            n_cmp++;
            if (evict_ready !== (pend() < DEPTH) || buf_empty !== (pend() == 0)) begin
                n_bad++;
                $display("FAIL rnd_flags c=%0d: ready=%b empty=%b pend=%0d",
                         c, evict_ready, buf_empty, pend());
            end
            n_cmp++;
            if (lookup_conflict !== model_conflict(lookup_addr)) begin
                n_bad++;
                $display("FAIL rnd_conflict c=%0d: got %b want %b",
                         c, lookup_conflict, model_conflict(lookup_addr));
            end
`ifdef L2_VICTIM_FORWARD_EN
            n_cmp++;
            if (lookup_hit !== model_conflict(lookup_addr) ||
                lookup_data !== model_fwd(lookup_addr)) begin
                n_bad++;
                $display("FAIL rnd_fwd c=%0d: hit=%b data=%h want %h",
                         c, lookup_hit, lookup_data, model_fwd(lookup_addr));
            end
`endif
            if (pmem_write) begin
                h = nbeats / NB;
                n_cmp++;
                if (h >= acc_q.size()) begin
                    n_bad++;
                    $display("FAIL rnd_spurious c=%0d: write=1 with no pending line", c);
                end else if (pmem_address !== align(acc_q[h].addr) ||
                             pmem_wdata !== slice(acc_q[h].data, nbeats % NB)) begin
                    n_bad++;
                    $display("FAIL rnd_beat c=%0d: addr=%h data=%h want %h %h", c,
                             pmem_address, pmem_wdata, align(acc_q[h].addr),
                             slice(acc_q[h].data, nbeats % NB));
                end
            end
            cycle();
        end
        drain(to);
        n_cmp++;
        if (to || obs_a.size() != acc_q.size() * NB) begin
            n_bad++;
            $display("FAIL rnd_drain: beats=%0d timeout=%b want %0d 0",
                     obs_a.size(), to, acc_q.size() * NB);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_fill();
        test_backpressure();
        test_conflict();
`ifdef L2_VICTIM_FORWARD_EN
        test_forward();
`endif
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, compared=%0d", n_cmp);
        $fatal(1);
    end

endmodule

// File: doc/l2_victim_buffer.md
Name: l2_victim_buffer

Overview:
- Downstream of the L2 data array: captures dirty victim lines the L2 controller evicts (line read out of the data array plus its line address).
- Queues them in a small FIFO and drains each line to physical memory as a fixed-length write burst.
- Decouples L2 miss servicing from writeback latency.
- Exposes an address-match check so the controller never fetches a line from memory while a newer copy is still queued.

Parameters:
- s_offset, 5, log2 bytes per line; line width s_line = 8*2**s_offset (256 bits).
- DEPTH, 2, number of victim entries (power of 2, ≥2).
- s_beat, 64, memory beat width in bits; BEATS = s_line/s_beat (4).

Ports:
- clk  in  1  clock.
- rst  in  1  reset.
- evict_valid  in  1  controller presents a victim line.
- evict_ready  out  1  buffer can accept a line.
- evict_addr  in  32  victim line address; bits [s_offset-1:0] ignored.
- evict_data  in  s_line  victim line data (data array dataout).
- lookup_addr  in  32  address the controller is about to fetch from memory.
- lookup_conflict  out  1  combinational; some valid entry has the same line address.
- buf_empty  out  1  no valid entries and no burst in progress.
- pmem_write  out  1  write burst request, held for whole burst.
- pmem_address  out  32  line-aligned address of head entry, low s_offset bits zero.
- pmem_wdata  out  s_beat  current beat = head data[s_beat*beat +: s_beat].
- pmem_resp  in  1  current beat accepted this cycle.

Interface decision: one clock; reset is asynchronous and active-low. The reset port is rst and is asserted when low.

Behaviour:
- Reset (rst low, asynchronous):
  - count, rd_ptr, wr_ptr, beat = 0; state = IDLE.
  - pmem_write = 0, pmem_address = 0, pmem_wdata = 0.
  - evict_ready = 1, buf_empty = 1, lookup_conflict = 0.
  - Entry data is not cleared; only valid bits clear.
- Enqueue:
  - evict_ready = (count < DEPTH), derived from registered count only.
  - On a clock edge with evict_valid & evict_ready: write {line addr, data} at wr_ptr, wr_ptr++ (wraps modulo DEPTH), set valid.
  - When full, a dequeue completing in the same cycle does NOT open a slot that cycle.
- FSM, states IDLE, BURST, GAP:
  - IDLE: if count > 0, go to BURST with beat = 0.
  - BURST: pmem_write = 1; pmem_address and pmem_wdata come from the head entry. On pmem_resp, beat++. When pmem_resp arrives on beat BEATS-1: pop the head (rd_ptr++, clear valid), go to GAP.
  - GAP: pmem_write = 0 for exactly one cycle, then IDLE.
  - With pmem_resp high every cycle, a line occupies BEATS+2 cycles: IDLE decision, BEATS cycles, GAP.
- Latency: a line accepted at edge E on an empty buffer gives pmem_write = 1 in the cycle after edge E+1.
- pmem_resp outside BURST is ignored.
- Simultaneous enqueue and pop: count unchanged, both pointers advance.
- Duplicate addresses may be queued; drain follows FIFO order, so the newest copy reaches memory last.
- pmem_address and pmem_wdata must stay stable while pmem_write is high and pmem_resp is low.
- buf_empty = (count == 0) & (state != BURST).
- Reset mid-burst: pmem_write drops immediately; all queued lines are discarded.

Optional Feature:
- Macro: L2_VICTIM_FORWARD_EN.
- When defined, adds outputs lookup_hit (1) and lookup_data (s_line), both combinational:
  - lookup_hit = lookup_conflict.
  - lookup_data = data of the youngest matching valid entry, so the controller refills from the buffer instead of stalling.
  - With no match, lookup_data = 0.
  - An entry being drained stays matchable until its pop edge.
- When undefined, these ports are absent. The controller must stall on lookup_conflict until the entry drains.

Decomposition:
- Package l2_pkg:
  - constant L2_BEAT_W = 64.
  - line-width localparams.
  - typedef enum vb_state_t {IDLE, BURST, GAP}.
  - typedef struct vb_entry_t {valid, line_addr[31:s_offset], data}.
- One sub-module, l2_vb_fifo: entry storage, pointers, count, address-match/youngest-select logic.
- Top level holds the burst FSM and beat counter.

Test Plan:
- Single eviction: addr 0x0000_1234, data beats 0x11..,0x22..,0x33..,0x44..; pmem_resp always high.
  - Expect pmem_address = 0x0000_1220, wdata in order 0x11..0x44, exactly 4 resp cycles, then one GAP cycle, then buf_empty = 1.
- Fill to full: enqueue 3 lines with pmem_resp held low.
  - Expect evict_ready = 0 after 2nd accept; 3rd held off.
  - Release resp: after 1st line pops, 3rd is accepted one cycle later; drain order is A, B, C.
- Backpressure: assert resp only on alternate cycles.
  - Expect pmem_address and pmem_wdata stable while resp is low; 4 beats complete in 8 cycles.
- Conflict: queue line 0x8000_0040, lookup_addr = 0x8000_005C.
  - Expect lookup_conflict = 1; 0 after that line's final beat.
- Reset mid-burst: drop rst after beat 1 accepted.
  - Expect pmem_write = 0 asynchronously, buf_empty = 1, no further beats after release.
- With L2_VICTIM_FORWARD_EN: queue two lines, same address, data X then Y.
  - Expect lookup_data = Y; after the first pop, still Y.
